// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector client: sector geometry and FSM state encoding.
package sd_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned SECTOR_AW    = 9;

    typedef enum logic [1:0] {
        SC_IDLE,
        SC_READ,
        SC_WRITE,
        SC_FIN
    } sc_state_e;

endpackage

// File: rtl/client_dpram.sv
// True dual-port 512x8 sector buffer with registered reads on both ports.
module client_dpram
    import sd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 a_we,
    input  logic [SECTOR_AW-1:0] a_addr,
    input  logic [7:0]           a_wdata,
    output logic [7:0]           a_rdata,
    input  logic                 b_we,
    input  logic [SECTOR_AW-1:0] b_addr,
    input  logic [7:0]           b_wdata,
    output logic [7:0]           b_rdata
);

    logic [7:0] mem [SECTOR_BYTES];

    // Both ports never write the same address in one cycle: the core port is gated by busy.
    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        if (b_we) mem[b_addr] <= b_wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_rdata <= 8'h00;
            b_rdata <= 8'h00;
        end else begin
            a_rdata <= mem[a_addr];
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/sd_sector_client.sv
// Core-side initiator for the SD wrapper sector interface with a one-sector cache.
module sd_sector_client
    import sd_pkg::*;
#(
    parameter logic [31:0] TIMEOUT  = 32'd0,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cmd_rd,
    input  logic                 cmd_wr,
    input  logic [31:0]          cmd_lba,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    input  logic [SECTOR_AW-1:0] buf_addr,
    input  logic [7:0]           buf_wdata,
    input  logic                 buf_we,
    output logic [7:0]           buf_rdata,
    output logic                 sd_rstart,
    output logic                 sd_wstart,
    output logic [31:0]          sd_sector,
    input  logic                 sd_rbusy,
    input  logic                 sd_rdone,
    input  logic                 sd_outen,
    input  logic [SECTOR_AW-1:0] sd_outaddr,
    input  logic [7:0]           sd_outbyte,
    output logic [7:0]           sd_inbyte
);

    sc_state_e   state_q, state_d;
    logic [31:0] sector_q, sector_d;
    logic [31:0] cached_lba_q, cached_lba_d;
    logic        cache_valid_q, cache_valid_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        hit_wait_q, hit_wait_d;
    logic        err_q, err_d;
    logic        cache_hit;
    logic        sd_rbusy_unused;

    assign sd_rbusy_unused = sd_rbusy;

    assign cache_hit = CACHE_EN && cache_valid_q && (cmd_lba == cached_lba_q);

    always_comb begin
        state_d       = state_q;
        sector_d      = sector_q;
        cached_lba_d  = cached_lba_q;
        cache_valid_d = cache_valid_q;
        tmo_cnt_d     = tmo_cnt_q;
        hit_wait_d    = hit_wait_q;
        err_d         = err_q;
        unique case (state_q)
            SC_IDLE: begin
                err_d = 1'b0;
                if (cmd_wr) begin
                    state_d   = SC_WRITE;
                    sector_d  = cmd_lba;
                    tmo_cnt_d = 32'd0;
                end else if (cmd_rd) begin
                    if (cache_hit) begin
                        // Extra FIN cycle keeps hit latency at two cycles.
                        state_d    = SC_FIN;
                        hit_wait_d = 1'b1;
                    end else begin
                        state_d       = SC_READ;
                        sector_d      = cmd_lba;
                        cache_valid_d = 1'b0;
                        tmo_cnt_d     = 32'd0;
                    end
                end
            end
            SC_READ, SC_WRITE: begin
                if (sd_rdone) begin
                    state_d       = SC_FIN;
                    cache_valid_d = 1'b1;
                    cached_lba_d  = sector_q;
                end else if (TIMEOUT != 32'd0 && tmo_cnt_q == TIMEOUT - 32'd1) begin
                    state_d       = SC_FIN;
                    err_d         = 1'b1;
                    cache_valid_d = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end
            SC_FIN: begin
                if (hit_wait_q) hit_wait_d = 1'b0;
                else            state_d    = SC_IDLE;
            end
            default: state_d = SC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= SC_IDLE;
            sector_q      <= 32'd0;
            cached_lba_q  <= 32'd0;
            cache_valid_q <= 1'b0;
            tmo_cnt_q     <= 32'd0;
            hit_wait_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sector_q      <= sector_d;
            cached_lba_q  <= cached_lba_d;
            cache_valid_q <= cache_valid_d;
            tmo_cnt_q     <= tmo_cnt_d;
            hit_wait_q    <= hit_wait_d;
            err_q         <= err_d;
        end
    end

    assign busy      = (state_q != SC_IDLE);
    assign sd_rstart = (state_q == SC_READ);
    assign sd_wstart = (state_q == SC_WRITE);
    assign sd_sector = sector_q;
    assign done      = (state_q == SC_FIN) && !hit_wait_q;
    assign error     = done && err_q;

    client_dpram u_dpram (
        .clk     (clk),
        .rstn    (rstn),
        .a_we    (sd_rstart && sd_outen),
        .a_addr  (sd_outaddr),
        .a_wdata (sd_outbyte),
        .a_rdata (sd_inbyte),
        .b_we    (buf_we && !busy),
        .b_addr  (buf_addr),
        .b_wdata (buf_wdata),
        .b_rdata (buf_rdata)
    );

endmodule

// File: tb/tb_sd_sector_client.sv
// Randomized self-checking bench for sd_sector_client against a sector/cache reference model.
module tb_sd_sector_client;
    import sd_pkg::*;

    localparam logic [31:0] TO = 32'd700;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_rd = 1'b0, cmd_wr = 1'b0;
    logic [31:0] cmd_lba = 32'd0;
    logic        busy, done, error;
    logic [8:0]  buf_addr = 9'd0;
    logic [7:0]  buf_wdata = 8'd0;
    logic        buf_we = 1'b0;
    logic [7:0]  buf_rdata;
    logic        sd_rstart, sd_wstart;
    logic [31:0] sd_sector;
    logic        sd_rbusy = 1'b0, sd_rdone = 1'b0, sd_outen = 1'b0;
    logic [8:0]  sd_outaddr = 9'd0;
    logic [7:0]  sd_outbyte = 8'd0;
    logic [7:0]  sd_inbyte;

    sd_sector_client #(.TIMEOUT(TO), .CACHE_EN(1'b1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_rd     (cmd_rd),
        .cmd_wr     (cmd_wr),
        .cmd_lba    (cmd_lba),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .buf_addr   (buf_addr),
        .buf_wdata  (buf_wdata),
        .buf_we     (buf_we),
        .buf_rdata  (buf_rdata),
        .sd_rstart  (sd_rstart),
        .sd_wstart  (sd_wstart),
        .sd_sector  (sd_sector),
        .sd_rbusy   (sd_rbusy),
        .sd_rdone   (sd_rdone),
        .sd_outen   (sd_outen),
        .sd_outaddr (sd_outaddr),
        .sd_outbyte (sd_outbyte),
        .sd_inbyte  (sd_inbyte)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Reference model: buffer image plus the single cache tag.
    logic [7:0]  mbuf [512];
    bit          m_valid = 1'b0;
    logic [31:0] m_lba = 32'd0;
    logic [7:0]  sdata [512];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic rd, input logic wr, input logic [31:0] lba);
        cmd_rd  = rd;
        cmd_wr  = wr;
        cmd_lba = lba;
        tick();
        cmd_rd  = 1'b0;
        cmd_wr  = 1'b0;
    endtask

    task automatic finish_xfer(input string tag);
        sd_rdone = 1'b1;
        tick();
        sd_rdone = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_err"}, {31'd0, error}, 32'd0);
        chk({tag, "_starts_drop"}, {30'd0, sd_rstart, sd_wstart}, 32'd0);
        chk({tag, "_busy_fin"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic core_fill(input bit rnd, input logic [7:0] val);
        for (int i = 0; i < 512; i++) begin
            buf_we    = 1'b1;
            buf_addr  = 9'(i);
            buf_wdata = rnd ? 8'($urandom) : val;
            mbuf[i]   = buf_wdata;
            tick();
        end
        buf_we = 1'b0;
    endtask

    task automatic rd_buf(input logic [8:0] a, output logic [7:0] d);
        buf_addr = a;
        tick();
        d = buf_rdata;
    endtask

    task automatic verify_buf(input string tag, input int n);
        logic [8:0] a;
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            a = 9'($urandom);
            rd_buf(a, d);
            chk(tag, {24'd0, d}, {24'd0, mbuf[a]});
        end
    endtask

    task automatic do_read(input logic [31:0] lba, input bit xor_pat);
        bit hit;
        int bad;
        hit = m_valid && (m_lba == lba);
        for (int i = 0; i < 512; i++) sdata[i] = xor_pat ? (8'(i) ^ 8'h5A) : 8'($urandom);
        send_cmd(1'b1, 1'b0, lba);
        chk("rd_busy_c1", {31'd0, busy}, 32'd1);
        if (hit) begin
            chk("hit_no_rstart", {31'd0, sd_rstart}, 32'd0);
            chk("hit_done_c1", {31'd0, done}, 32'd0);
            tick();
            chk("hit_done_c2", {30'd0, done, sd_rstart}, 32'd2);
            tick();
            chk("hit_busy_end", {31'd0, busy}, 32'd0);
        end else begin
            chk("miss_rstart", {31'd0, sd_rstart}, 32'd1);
            chk("miss_sector", sd_sector, lba);
            bad = 0;
            for (int c = 0; c < 50; c++) begin
                if (sd_rstart !== 1'b1 || done !== 1'b0 || sd_sector !== lba) bad++;
                tick();
            end
            for (int i = 0; i < 512; i++) begin
                sd_outen   = 1'b1;
                sd_outaddr = 9'(i);
                sd_outbyte = sdata[i];
                if (sd_rstart !== 1'b1 || done !== 1'b0 || sd_sector !== lba) bad++;
                tick();
            end
            sd_outen = 1'b0;
            chk("miss_hold", bad, 0);
            finish_xfer("rd");
            for (int i = 0; i < 512; i++) mbuf[i] = sdata[i];
            m_valid = 1'b1;
            m_lba   = lba;
        end
    endtask

    task automatic do_write(input logic [31:0] lba);
        int bad;
        int hold_bad;
        send_cmd(1'b0, 1'b1, lba);
        chk("wr_starts", {30'd0, sd_rstart, sd_wstart}, 32'd1);
        chk("wr_sector", sd_sector, lba);
        bad = 0;
        hold_bad = 0;
        for (int i = 0; i < 512; i++) begin
            sd_outaddr = 9'(i);
            tick();
            if (sd_inbyte !== mbuf[i]) bad++;
            if (sd_wstart !== 1'b1 || done !== 1'b0) hold_bad++;
        end
        chk("wr_bytes", bad, 0);
        chk("wr_hold", hold_bad, 0);
        finish_xfer("wr");
        m_valid = 1'b1;
        m_lba   = lba;
    endtask

    initial begin
        logic [7:0]  d;
        logic [31:0] lba;
        int          k;

        // Reset state
        repeat (3) tick();
        chk("rst_ctl", {27'd0, busy, done, error, sd_rstart, sd_wstart}, 32'd0);
        chk("rst_sector", sd_sector, 32'd0);
        chk("rst_rdata", {16'd0, buf_rdata, sd_inbyte}, 32'd0);
        rstn = 1'b1;
        tick();

        // Read miss, then hit, then neighbouring miss
        do_read(32'h1234, 1'b1);
        rd_buf(9'd7, d);
        chk("buf_7", {24'd0, d}, 32'h5D);
        do_read(32'h1234, 1'b0);
        do_read(32'h1235, 1'b0);
        verify_buf("rd_buf", 16);

        // Write from core-filled buffer, then read of same LBA hits
        core_fill(1'b0, 8'hA5);
        do_write(32'h10);
        do_read(32'h10, 1'b0);
        verify_buf("wr_buf", 8);

        // Simultaneous read+write: write wins; commands and core writes ignored while busy
        core_fill(1'b1, 8'h00);
        send_cmd(1'b1, 1'b1, 32'h77);
        chk("both_starts", {30'd0, sd_rstart, sd_wstart}, 32'd1);
        cmd_rd    = 1'b1;
        cmd_lba   = 32'h99;
        buf_we    = 1'b1;
        buf_addr  = 9'd3;
        buf_wdata = ~mbuf[3];
        tick();
        cmd_rd = 1'b0;
        buf_we = 1'b0;
        chk("busy_cmd_ign", {30'd0, sd_rstart, sd_wstart}, 32'd1);
        chk("busy_sector", sd_sector, 32'h77);
        finish_xfer("both");
        m_valid = 1'b1;
        m_lba   = 32'h77;
        rd_buf(9'd3, d);
        chk("busy_we_ign", {24'd0, d}, {24'd0, mbuf[3]});
        do_read(32'h77, 1'b0);

        // Timeout: no sd_rdone ever arrives
        lba = 32'h5000 + 32'($urandom_range(0, 255));
        send_cmd(1'b1, 1'b0, lba);
        chk("to_rstart", {31'd0, sd_rstart}, 32'd1);
        m_valid = 1'b0;
        k = 1;
        while (done !== 1'b1 && k < 2 * int'(TO)) begin
            tick();
            k++;
        end
        chk("to_cycle", k, int'(TO) + 1);
        chk("to_err", {31'd0, error}, 32'd1);
        chk("to_start_low", {31'd0, sd_rstart}, 32'd0);
        tick();
        chk("to_busy_end", {30'd0, busy, error}, 32'd0);
        do_read(lba, 1'b0);

        // Reset in the middle of a read
        lba = 32'h7000 + 32'($urandom_range(0, 255));
        send_cmd(1'b1, 1'b0, lba);
        for (int i = 0; i < 200; i++) begin
            sd_outen   = 1'b1;
            sd_outaddr = 9'(i);
            sd_outbyte = 8'($urandom);
            mbuf[i]    = sd_outbyte;
            tick();
        end
        sd_outen = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_ctl", {27'd0, busy, done, error, sd_rstart, sd_wstart}, 32'd0);
        chk("mid_rst_sector", sd_sector, 32'd0);
        chk("mid_rst_rdata", {16'd0, buf_rdata, sd_inbyte}, 32'd0);
        m_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("mid_rst_nodone", {31'd0, done}, 32'd0);
        verify_buf("partial_buf", 6);
        do_read(lba, 1'b0);

        // Random mix over two neighbouring LBAs so hits and misses both occur
        lba = 32'($urandom);
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                core_fill(1'b1, 8'h00);
                do_write(lba + 32'($urandom_range(0, 1)));
            end else begin
                do_read(lba + 32'($urandom_range(0, 1)), 1'b0);
            end
            verify_buf("rand_buf", 8);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
